// File: rtl/lsu_sequencer_if.sv
// Memory-side bus of the load/store sequencer: request with byte enables and
// lane-replicated write data, answered by a ready strobe carrying the read word.
interface lsu_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [3:0]            mem_be_o;
  logic [31:0]           mem_wdata_o;
  logic                  mem_ready_i;
  logic [31:0]           mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  mem_ready_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output mem_ready_i, mem_rdata_i
  );
endinterface

// File: rtl/lsu_sequencer.sv
// Load/store sequencer between the CPU memory stage and a variable-latency word RAM.
// Optional access timeout is built when MEM_TIMEOUT_EN is defined.
module lsu_sequencer #(
  parameter int unsigned ADDR_WIDTH = 32
`ifdef MEM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            memType_i,
  input  logic                  memSign_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [31:0]           rdata_o,
  lsu_sequencer_if.master       mem
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  type_q;
  logic        sign_q;
  logic [1:0]  lane_q;
  logic        illegal;
  logic        timeout_hit;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign illegal = (memType_i == 2'b11)
                 | ((memType_i == 2'b10) & addr_i[0])
                 | ((memType_i == 2'b00) & (|addr_i[1:0]));

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_q;
  // Checked one cycle early so the request drops after exactly TIMEOUT_CYCLES waits.
  assign timeout_hit = !mem.mem_ready_i && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_o = req_i;
        if (req_i) state_d = illegal ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        stall_o = 1'b1;
        if (mem.mem_ready_i || timeout_hit) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = wdata_i;
    case (memType_i)
      2'b01: begin
        be_d    = 4'b0001 << addr_i[1:0];
        wdata_d = {4{wdata_i[7:0]}};
      end
      2'b10: begin
        be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the latched address so input changes mid-access are harmless.
  assign shifted = mem.mem_rdata_i >> {lane_q, 3'b000};

  always_comb begin
    load_data = mem.mem_rdata_i;
    case (type_q)
      2'b01: load_data = {{24{sign_q & shifted[7]}}, shifted[7:0]};
      2'b10: load_data = {{16{sign_q & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem.mem_req_o   <= 1'b0;
      mem.mem_we_o    <= 1'b0;
      mem.mem_addr_o  <= '0;
      mem.mem_be_o    <= 4'b0000;
      mem.mem_wdata_o <= 32'h0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
      rdata_o         <= 32'h0;
      type_q          <= 2'b00;
      sign_q          <= 1'b0;
      lane_q          <= 2'b00;
`ifdef MEM_TIMEOUT_EN
      cnt_q           <= 8'd0;
`endif
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_i && illegal) begin
            done_o  <= 1'b1;
            err_o   <= 1'b1;
            rdata_o <= 32'h0;
          end else if (req_i) begin
            mem.mem_req_o   <= 1'b1;
            mem.mem_we_o    <= we_i;
            mem.mem_addr_o  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
            mem.mem_be_o    <= be_d;
            mem.mem_wdata_o <= wdata_d;
            type_q          <= memType_i;
            sign_q          <= memSign_i;
            lane_q          <= addr_i[1:0];
`ifdef MEM_TIMEOUT_EN
            cnt_q           <= 8'd0;
`endif
          end
        end
        S_ACCESS: begin
          if (mem.mem_ready_i) begin
            mem.mem_req_o <= 1'b0;
            done_o        <= 1'b1;
            rdata_o       <= mem.mem_we_o ? 32'h0 : load_data;
          end else if (timeout_hit) begin
            mem.mem_req_o <= 1'b0;
            done_o        <= 1'b1;
            err_o         <= 1'b1;
            rdata_o       <= 32'h0;
          end
`ifdef MEM_TIMEOUT_EN
          if (!mem.mem_ready_i) cnt_q <= cnt_q + 8'd1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Randomised self-checking bench for lsu_sequencer against a transaction-level model.
// Define MEM_TIMEOUT_EN for both files to exercise the timeout with a limit of 4.
module tb_lsu_sequencer;

`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic        we_i;
  logic [1:0]  memType_i;
  logic        memSign_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] rdata_o;

  lsu_sequencer_if #(.ADDR_WIDTH(32)) bus ();

  lsu_sequencer #(
    .ADDR_WIDTH(32)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .we_i      (we_i),
    .memType_i (memType_i),
    .memSign_i (memSign_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .stall_o   (stall_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .rdata_o   (rdata_o),
    .mem       (bus.master)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit        we;
    bit [1:0]  mtype;
    bit        sign;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] word;
    int        waits;
  } op_t;

  function automatic op_t mk(bit we, bit [1:0] mtype, bit sign, bit [31:0] addr,
                             bit [31:0] wdata, bit [31:0] word, int waits);
    op_t o;
    o.we = we; o.mtype = mtype; o.sign = sign; o.addr = addr;
    o.wdata = wdata; o.word = word; o.waits = waits;
    return o;
  endfunction

  // Reference model: access size in bytes, alignment by modulo, lanes by byte arithmetic.
  function automatic int op_size(bit [1:0] t);
    case (t)
      2'd0: return 4;
      2'd1: return 1;
      2'd2: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic bit op_illegal(op_t o);
    int s = op_size(o.mtype);
    return (s == 0) || ((o.addr % s) != 0);
  endfunction

  function automatic logic [3:0] exp_be(op_t o);
    int s = op_size(o.mtype);
    int v = ((1 << s) - 1) << (o.addr % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(op_t o);
    int s = op_size(o.mtype);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = o.wdata[8*(i % s) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(op_t o);
    int s = op_size(o.mtype);
    logic [31:0] mask, v;
    mask = (s == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*s)) - 32'h1);
    v = (o.word >> (8 * (o.addr % 4))) & mask;
    if (o.sign && s < 4 && v[8*s-1]) v = v | ~mask;
    return v;
  endfunction

  bit in_resp = 0;

  task automatic run_op(input op_t o, input string name);
    bit ill, tmo, rdy;
    int done_c;
    ill    = op_illegal(o);
    tmo    = !ill && TMO > 0 && o.waits >= TMO;
    done_c = ill ? 1 : (tmo ? TMO + 1 : o.waits + 2);
    req_i = 1'b1; we_i = o.we; memType_i = o.mtype; memSign_i = o.sign;
    addr_i = o.addr; wdata_i = o.wdata;
    bus.mem_ready_i = 1'($urandom);
    bus.mem_rdata_i = $urandom;
    #1;
    if (in_resp) begin
      check({name, " resp stall"}, stall_o, 0);
      @(posedge clk_i); #1;
      check({name, " resp ignores req"}, done_o, 0);
    end
    check({name, " c0 stall"}, stall_o, 1);
    check({name, " c0 req"}, bus.mem_req_o, 0);
    for (int c = 1; c <= done_c; c++) begin
      @(posedge clk_i); #1;
      if (c < done_c) begin
        check($sformatf("%s c%0d done", name, c), done_o, 0);
        check($sformatf("%s c%0d stall", name, c), stall_o, 1);
        check($sformatf("%s c%0d req", name, c), bus.mem_req_o, 1);
        check($sformatf("%s c%0d addr", name, c), bus.mem_addr_o, o.addr & 32'hFFFF_FFFC);
        check($sformatf("%s c%0d be", name, c), bus.mem_be_o, exp_be(o));
        check($sformatf("%s c%0d we", name, c), bus.mem_we_o, o.we);
        if (o.we) check($sformatf("%s c%0d wdata", name, c), bus.mem_wdata_o, exp_wdata(o));
        rdy = (c - 1 == o.waits);
        bus.mem_ready_i = rdy;
        bus.mem_rdata_i = rdy ? o.word : $urandom;
        addr_i = $urandom; wdata_i = $urandom; memType_i = 2'($urandom);
        memSign_i = 1'($urandom); we_i = 1'($urandom);
      end else begin
        check($sformatf("%s c%0d done", name, c), done_o, 1);
        check({name, " err"}, err_o, ill || tmo);
        check({name, " rdata"}, rdata_o, (ill || tmo || o.we) ? 32'h0 : exp_load(o));
        check({name, " done stall"}, stall_o, 0);
        check({name, " done req"}, bus.mem_req_o, 0);
        bus.mem_ready_i = 1'($urandom);
      end
    end
    in_resp = 1;
  endtask

  task automatic idle_cycle();
    req_i = 1'b0;
    @(posedge clk_i); #1;
    check("idle stall", stall_o, 0);
    check("idle done", done_o, 0);
    check("idle req", bus.mem_req_o, 0);
    in_resp = 0;
  endtask

  task automatic check_cleared(input string name);
    check({name, " req"}, bus.mem_req_o, 0);
    check({name, " we"}, bus.mem_we_o, 0);
    check({name, " addr"}, bus.mem_addr_o, 0);
    check({name, " be"}, bus.mem_be_o, 0);
    check({name, " wdata"}, bus.mem_wdata_o, 0);
    check({name, " done"}, done_o, 0);
    check({name, " err"}, err_o, 0);
    check({name, " rdata"}, rdata_o, 0);
    check({name, " stall"}, stall_o, 0);
  endtask

  initial begin
    op_t o;
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; memType_i = 2'b00; memSign_i = 1'b0;
    addr_i = 32'h0; wdata_i = 32'h0;
    bus.mem_ready_i = 1'b0; bus.mem_rdata_i = 32'h0;

    for (int i = 0; i < 2; i++) begin
      @(posedge clk_i); #1;
      check_cleared($sformatf("reset%0d", i));
    end
    rst_ni = 1'b1;

    // Reset during ACCESS abandons the request without a completion pulse.
    req_i = 1'b1; we_i = 1'b0; memType_i = 2'b00; addr_i = 32'h10;
    @(posedge clk_i); #1;
    check("mid-rst req up", bus.mem_req_o, 1);
    @(posedge clk_i); #1;
    rst_ni = 1'b0; req_i = 1'b0;
    @(posedge clk_i); #1;
    check_cleared("mid-rst");
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check_cleared("post-rst");

    run_op(mk(0, 2'b01, 1, 32'h103, 32'h0, 32'h8000_0000, 0), "lb signed");
    idle_cycle();
    run_op(mk(0, 2'b01, 0, 32'h103, 32'h0, 32'h8000_0000, 0), "lb unsigned");
    idle_cycle();
    run_op(mk(1, 2'b10, 0, 32'h22, 32'h1234_ABCD, 32'h0, 3), "sh wait3");
    idle_cycle();
    run_op(mk(0, 2'b00, 0, 32'h41, 32'h0, 32'h0, 0), "lw misaligned");
    idle_cycle();
    run_op(mk(0, 2'b11, 0, 32'h40, 32'h0, 32'h0, 0), "illegal type");
    idle_cycle();
    run_op(mk(0, 2'b00, 0, 32'h0, 32'h0, 32'hDEAD_BEEF, 0), "b2b lw");
    run_op(mk(1, 2'b01, 0, 32'h5, 32'h0000_0077, 32'h0, 0), "b2b sb");
    idle_cycle();
    run_op(mk(0, 2'b00, 0, 32'h80, 32'h0, 32'hCAFE_F00D, 4), "lw wait4");
    idle_cycle();
    run_op(mk(0, 2'b10, 1, 32'h82, 32'h0, 32'h9876_5432, 3), "lh wait3");
    idle_cycle();

    for (int n = 0; n < 80; n++) begin
      o = mk(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom,
             $urandom, int'($urandom_range(0, 5)));
      if ($urandom_range(0, 7) != 0 && o.mtype != 2'b11)
        o.addr = o.addr & ~(32'(op_size(o.mtype)) - 32'h1);
      run_op(o, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
